// File: rtl/cpu_defs.sv
// Shared datapath encodings for selector users and skid storage.
// Occupancy states of the two-entry skid buffer live here too.
package cpu_defs;

   localparam int PCSRC_PC4 = 0;
   localparam int PCSRC_BR  = 1;
   localparam int PCSRC_J   = 2;
   localparam int PCSRC_JR  = 3;

   typedef enum logic [1:0] {
      BUS_RAM = 2'd0,
      BUS_LED = 2'd1,
      BUS_SEG = 2'd2
   } bus_sel_e;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

endpackage

// File: rtl/skid_reg.sv
// Two-entry main/skid register with valid/ready handshake.
// in_ready and out_valid are flops decoded from the next state.
module skid_reg
   import cpu_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   occ_e             state_q;
   occ_e             state_d;
   logic             rdy_q;
   logic             vld_q;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             acc;
   logic             xfer;
   logic             ld_in;
   logic             ld_skid;
   logic             ld_drain;

   assign acc  = in_valid & rdy_q;
   assign xfer = vld_q & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OCC_EMPTY;
         rdy_q   <= 1'b1;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= (state_d != OCC_FULL);
         vld_q   <= (state_d != OCC_EMPTY);
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = OCC_EMPTY;
      end else begin
         case (state_q)
            OCC_EMPTY: if (acc) state_d = OCC_ONE;
            OCC_ONE: begin
               if (acc && !xfer)      state_d = OCC_FULL;
               else if (!acc && xfer) state_d = OCC_EMPTY;
            end
            OCC_FULL:  if (xfer) state_d = OCC_ONE;
            default:   state_d = OCC_EMPTY;
         endcase
      end
   end

   always_comb begin
      ld_in    = 1'b0;
      ld_skid  = 1'b0;
      ld_drain = 1'b0;
      if (!flush) begin
         case (state_q)
            OCC_EMPTY: ld_in = acc;
            OCC_ONE: begin
               ld_in   = acc & xfer;
               ld_skid = acc & ~xfer;
            end
            OCC_FULL:  ld_drain = xfer;
            default:   ld_in = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (flush)         main_q <= '0;
         else if (ld_in)    main_q <= in_data;
         else if (ld_drain) main_q <= skid_q;
         if (ld_skid) skid_q <= in_data;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = vld_q;
   assign out_data  = main_q;

endmodule

// File: rtl/muxnx_pipe.sv
// Registered N:1 selector: select/DEFVAL front end over a skid_reg.
// Out-of-range selects store DEFVAL and pulse sel_err once.
module muxnx_pipe #(
   parameter int               WIDTH  = 32,
   parameter int               NUM    = 4,
   parameter int               SELW   = $clog2(NUM),
   parameter logic [WIDTH-1:0] DEFVAL = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM*WIDTH-1:0] in_data,
   input  logic [SELW-1:0]      in_sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 flush,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 sel_err
);

   // one extra bit keeps the range compare meaningful for power-of-two NUM
   localparam logic [SELW:0] NUMV = NUM[SELW:0];

   logic [SELW:0]    sel_x;
   logic             oor;
   logic [WIDTH-1:0] word;
   logic             acc;
   logic             err_q;

   assign sel_x = {1'b0, in_sel};
   assign oor   = (sel_x >= NUMV);
   assign acc   = in_valid & in_ready;

   always_comb begin
      word = DEFVAL;
      for (int k = 0; k < NUM; k++) begin
         if (sel_x == k[SELW:0]) word = in_data[k*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= ~flush & acc & oor;
   end

   assign sel_err = err_q;

   skid_reg #(
      .WIDTH(WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_data   (word),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

endmodule

// File: doc/muxnx_pipe.md
# muxnx_pipe

Parametrised N-input, WIDTH-bit registered multiplexer with a valid/ready handshake and a two-entry skid buffer. It is the pipelined replacement for the plain 2:1 combinational selectors in the datapath. Its main uses are next-PC source selection (PC+4 / branch / jump / jr) and bus read-data return from RAM, LED and segment slaves. Because the select-to-data path is registered, IF and the bus decode are no longer on one combinational path, and back-pressure from a stalled consumer is handled without losing data.

## Interface
- WIDTH, 32, data width of each input and of the output
- NUM, 4, number of inputs (2..16)
- SELW, $clog2(NUM), select width (derived; do not override)
- DEFVAL, 0, value output when the select is out of range (sel >= NUM)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  NUM*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
- in_sel  in  SELW  binary select, sampled with in_data
- in_valid  in  1  producer offers in_data/in_sel this cycle
- in_ready  out  1  block can accept; registered
- flush  in  1  synchronous discard of all held data
- out_data  out  WIDTH  selected word; registered
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts out_data this cycle
- sel_err  out  1  one-cycle pulse: an accepted transfer had sel >= NUM

## Operation
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- On accept, the selected word is computed as in_data[in_sel] (or DEFVAL when in_sel >= NUM) and captured.
- Two storage entries:
  - main drives out_data/out_valid.
  - skid holds one word that arrives while main is stalled.
- States, encoded by occupancy:
  - EMPTY: main invalid, skid invalid, in_ready=1.
  - ONE: main valid, skid invalid, in_ready=1.
  - FULL: main valid, skid valid, in_ready=0.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept and no out transfer -> FULL; the word goes to skid.
  - ONE + accept and out transfer -> ONE; main is replaced.
  - ONE + out transfer only -> EMPTY.
  - FULL + out transfer -> ONE; skid moves to main.
  - FULL never accepts, because in_ready=0.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- Select handling:
  - in_sel >= NUM stores DEFVAL.
  - sel_err pulses high for the cycle following the accepting edge.
  - Out-of-range selects are only reachable when NUM is not a power of two.
- flush: at the next edge, both entries are cleared (-> EMPTY) and in_ready=1. An input presented in the flush cycle is discarded and raises no sel_err. flush has priority over every simultaneous transfer.
- Reset (rst_n low, any time, including mid-transfer), asynchronous:
  - out_valid=0, out_data=0, in_ready=1, sel_err=0.
  - Skid contents are discarded.
  - Operation resumes on the first edge after rst_n rises.

## Timing
- Latency: an accept at edge t gives out_valid=1 with the word after edge t, visible in cycle t+1.
- Throughput: one word per cycle while out_ready=1.
- in_ready is a flop output. No combinational path from out_ready to in_ready.
- No combinational path from any input to any output.
- A stall of one or more cycles costs no bubble on release: FULL -> ONE drains skid with in_ready=1 in the same cycle.
- Holding rule: while out_valid=1 and out_ready=0, out_data is stable.
- Producer rule: the producer must not change in_data/in_sel while in_valid=1 and in_ready=0. The bench asserts this rule.

## Structure
- Shared package cpu_defs:
  - PC-source select encodings: PCSRC_PC4=0, PCSRC_BR=1, PCSRC_J=2, PCSRC_JR=3.
  - Bus slave select encodings: RAM, LED, SEG.
  - Users instantiate with NUM and these encodings. muxnx_pipe itself imports nothing.
- Sub-module skid_reg: the two-entry main/skid storage plus occupancy FSM, parametrised on WIDTH.
- muxnx_pipe is the select/DEFVAL/sel_err front end plus one skid_reg.

## Test plan
- Reset/idle:
  - Stimulus: rst_n low mid-stream.
  - Required: out_valid=0, out_data=0, in_ready=1 immediately; after release, the first accept of sel=2 with in_data word2=0x0000_00C8 gives out_data=0x0000_00C8 one cycle later.
- Streaming (NUM=4):
  - Stimulus: out_ready=1; feed sel=0,1,2,3 on consecutive cycles with words 0x10,0x20,0x30,0x40.
  - Required: outputs 0x10..0x40 on consecutive cycles with no gaps.
- Back-pressure:
  - Stimulus: out_ready=0 for 3 cycles while feeding 0xA1,0xA2,0xA3.
  - Required: in_ready falls after 0xA2 is accepted; 0xA3 is held by the producer; release delivers 0xA1,0xA2,0xA3 in order, one per cycle.
- Flush:
  - Stimulus: in FULL, assert flush together with in_valid (word 0xBEEF).
  - Required: next cycle out_valid=0, in_ready=1; 0xBEEF never appears.
- Out-of-range (NUM=3, DEFVAL=0xDEAD_BEEF):
  - Stimulus: accept sel=3.
  - Required: out_data=0xDEAD_BEEF; sel_err pulses for exactly one cycle.
- Randomised scoreboard:
  - Stimulus: 10k random in_valid/out_ready/sel over NUM ∈ {2,3,8}.
  - Required: every accepted word delivered once, in order.
